// File: rtl/dw_sincos_cordic_seq.sv
// Iterative CORDIC sine/cosine generator with valid/ready handshakes on both sides.
// Optional phase accumulator on the input: define DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN.
module dw_sincos_cordic_seq #(
  parameter int A_WIDTH    = 24,
  parameter int WAVE_WIDTH = 25,
  parameter int ITER       = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_WIDTH-1:0]    a,
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
  input  logic                  acc_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WAVE_WIDTH-1:0] sin_out,
  output logic [WAVE_WIDTH-1:0] cos_out,
  output logic                  busy
);
  localparam int XW = WAVE_WIDTH + 3;
  localparam int ZW = A_WIDTH + 1;
  localparam int SH = 32 - A_WIDTH;
  localparam longint X0L = longint'(0.6072529350088813 * (2.0 ** WAVE_WIDTH));
  localparam logic signed [XW-1:0] X0 = XW'(X0L);
  localparam logic [32:0] RND = 33'((longint'(1) << SH) >> 1);
  localparam logic signed [XW:0] SAT_P = (XW+1)'((longint'(1) << (WAVE_WIDTH-1)) - 1);
  localparam logic signed [XW:0] SAT_N = -SAT_P;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  // atan(2^-i) in units of 2^-32 turn
  function automatic logic [31:0] atan32(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h20000000;  5'd1:  return 32'h12E4051E;
      5'd2:  return 32'h09FB385B;  5'd3:  return 32'h051111D4;
      5'd4:  return 32'h028B0D43;  5'd5:  return 32'h0145D7E1;
      5'd6:  return 32'h00A2F61E;  5'd7:  return 32'h00517C55;
      5'd8:  return 32'h0028BE53;  5'd9:  return 32'h00145F2F;
      5'd10: return 32'h000A2F98;  5'd11: return 32'h000517CC;
      5'd12: return 32'h00028BE6;  5'd13: return 32'h000145F3;
      5'd14: return 32'h0000A2FA;  5'd15: return 32'h0000517D;
      5'd16: return 32'h000028BE;  5'd17: return 32'h0000145F;
      5'd18: return 32'h00000A30;  5'd19: return 32'h00000518;
      5'd20: return 32'h0000028C;  5'd21: return 32'h00000146;
      5'd22: return 32'h000000A3;  5'd23: return 32'h00000051;
      5'd24: return 32'h00000029;  5'd25: return 32'h00000014;
      5'd26: return 32'h0000000A;  5'd27: return 32'h00000005;
      5'd28: return 32'h00000003;  5'd29: return 32'h00000001;
      5'd30: return 32'h00000001;  default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic signed [ZW-1:0] atan_a(input logic [4:0] i);
    logic [32:0] t;
    t = ({1'b0, atan32(i)} + RND) >> SH;
    return ZW'(t);
  endfunction

  // drop the two guard bits (round half up), then clamp symmetrically
  function automatic logic [WAVE_WIDTH-1:0] conv(input logic signed [XW-1:0] v);
    logic signed [XW:0] t;
    t = ($signed({v[XW-1], v}) + $signed((XW+1)'(2))) >>> 2;
    if (t > SAT_P) return SAT_P[WAVE_WIDTH-1:0];
    if (t < SAT_N) return SAT_N[WAVE_WIDTH-1:0];
    return t[WAVE_WIDTH-1:0];
  endfunction

  state_t                  state_q;
  logic signed [XW-1:0]    x_q, y_q;
  logic signed [ZW-1:0]    z_q;
  logic [4:0]              i_q;
  logic [1:0]              quad_q;
  logic [WAVE_WIDTH-1:0]   sin_q, cos_q;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic [A_WIDTH-1:0]      ang_d;

`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
  logic [A_WIDTH-1:0]      phase_q;
  assign ang_d = acc_mode ? phase_q + a : a;
`else
  assign ang_d = a;
`endif

  logic                    dir;
  logic signed [XW-1:0]    xs, ys, x_d, y_d, s_pre, c_pre;
  logic signed [ZW-1:0]    z_d;

  always_comb begin
    dir = ~z_q[ZW-1];
    xs  = x_q >>> i_q;
    ys  = y_q >>> i_q;
    x_d = dir ? x_q - ys : x_q + ys;
    y_d = dir ? y_q + xs : y_q - xs;
    z_d = dir ? z_q - atan_a(i_q) : z_q + atan_a(i_q);
    case (quad_q)
      2'd0:    begin s_pre = y_d;  c_pre = x_d;  end
      2'd1:    begin s_pre = x_d;  c_pre = -y_d; end
      2'd2:    begin s_pre = -y_d; c_pre = -x_d; end
      default: begin s_pre = -x_d; c_pre = y_d;  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      quad_q      <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
      phase_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            quad_q     <= ang_d[A_WIDTH-1:A_WIDTH-2];
            z_q        <= {3'b000, ang_d[A_WIDTH-3:0]};
            x_q        <= X0;
            y_q        <= '0;
            i_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ITER;
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
            phase_q    <= ang_d;
`endif
          end
        end
        S_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (i_q == 5'(ITER-1)) begin
            sin_q       <= conv(s_pre);
            cos_q       <= conv(c_pre);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
endmodule

// File: tb/tb_dw_sincos_cordic_seq.sv
// Directed bench for dw_sincos_cordic_seq: handshake timing, hold, reset abort and numeric results.
module tb_dw_sincos_cordic_seq;
  localparam int  IT  = 22;
  localparam longint TOL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] a = '0;
  logic        in_ready, out_valid, busy;
  logic [24:0] sin_out, cos_out;
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
  logic        acc_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dw_sincos_cordic_seq #(.A_WIDTH(24), .WAVE_WIDTH(25), .ITER(IT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
    .acc_mode(acc_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sin_out(sin_out), .cos_out(cos_out), .busy(busy)
  );

  // reference: arctangent table derived from real math, 24-bit angle units
  function automatic longint atan_tab(input int i);
    real    r;
    longint t;
    r = $atan(1.0 / (2.0 ** i)) / (2.0 * 3.141592653589793) * 4294967296.0;
    t = longint'($floor(r + 0.5));
    return (t + 128) >>> 8;
  endfunction

  function automatic longint rnd_sat(input longint v);
    longint t;
    t = (v + 2) >>> 2;
    if (t > 16777215) t = 16777215;
    if (t < -16777215) t = -16777215;
    return t;
  endfunction

  task automatic model(input logic [23:0] ang, output longint s, output longint c);
    longint x, y, z, xn, sv, cv;
    x = longint'(0.6072529350088813 * 33554432.0);
    y = 0;
    z = longint'(ang[21:0]);
    for (int i = 0; i < IT; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab(i);
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab(i);
      end
      x = xn;
    end
    case (ang[23:22])
      2'd0:    begin sv = y;  cv = x;  end
      2'd1:    begin sv = x;  cv = -y; end
      2'd2:    begin sv = -y; cv = -x; end
      default: begin sv = -x; cv = y;  end
    endcase
    s = rnd_sat(sv);
    c = rnd_sat(cv);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready got in_ready=%b exp 1 within 200 cycles", in_ready);
    end
  endtask

  // accept one angle and check the result; leaves the DUT in DONE
  task automatic run_angle(input string nm, input logic [23:0] drv, input logic [23:0] eff,
                           input longint is, input longint ic);
    longint ms, mc, gs, gc, ds, dc;
    wait_ready();
    a = drv; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = ~drv;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s accept got busy=%b in_ready=%b exp 1/0", nm, busy, in_ready);
    end
    repeat (IT - 1) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid got %b exp 0", nm, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency got out_valid=%b exp 1", nm, out_valid);
    end
    model(eff, ms, mc);
    gs = longint'($signed(sin_out));
    gc = longint'($signed(cos_out));
    checks++;
    if (gs != ms || gc != mc) begin
      errors++;
      $display("FAIL %s exact got sin=%0d cos=%0d exp sin=%0d cos=%0d", nm, gs, gc, ms, mc);
    end
    ds = gs - is; dc = gc - ic;
    if (ds < 0) ds = -ds;
    if (dc < 0) dc = -dc;
    checks++;
    if (ds > TOL || dc > TOL) begin
      errors++;
      $display("FAIL %s approx got sin=%0d cos=%0d exp sin=%0d cos=%0d", nm, gs, gc, is, ic);
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release got out_valid=%b in_ready=%b busy=%b exp 0/1/0",
               nm, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sin_out !== 25'd0 || cos_out !== 25'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b sin=%h cos=%h exp all 0",
               in_ready, out_valid, busy, sin_out, cos_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_angles();
    run_angle("a_0",     24'h000000, 24'h000000, 0,        8388608);  release_out("a_0");
    run_angle("a_90",    24'h400000, 24'h400000, 8388608,  0);        release_out("a_90");
    run_angle("a_270",   24'hC00000, 24'hC00000, -8388608, 0);        release_out("a_270");
    run_angle("a_45",    24'h200000, 24'h200000, 5931642,  5931642);  release_out("a_45");
    run_angle("a_225",   24'hA00000, 24'hA00000, -5931642, -5931642); release_out("a_225");
    run_angle("a_135",   24'h600000, 24'h600000, 5931642,  -5931642); release_out("a_135");
    run_angle("a_30",    24'h155555, 24'h155555, 4194304,  7264748);  release_out("a_30");
  endtask

  task automatic test_hold();
    longint ms, mc;
    int bad;
    run_angle("hold_45", 24'h200000, 24'h200000, 5931642, 5931642);
    model(24'h200000, ms, mc);
    a = 24'hC00000; in_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          longint'($signed(sin_out)) != ms || longint'($signed(cos_out)) != mc) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold got %0d bad cycles exp 0 (last vld=%b rdy=%b sin=%0d cos=%0d)",
               bad, out_valid, in_ready, $signed(sin_out), $signed(cos_out));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_reaccept got busy=%b rdy=%b exp 1/0", busy, in_ready);
    end
    repeat (IT) @(negedge clk);
    model(24'hC00000, ms, mc);
    checks++;
    if (out_valid !== 1'b1 || longint'($signed(sin_out)) != ms || longint'($signed(cos_out)) != mc) begin
      errors++;
      $display("FAIL hold_next got vld=%b sin=%0d cos=%0d exp 1 sin=%0d cos=%0d",
               out_valid, $signed(sin_out), $signed(cos_out), ms, mc);
    end
    release_out("hold_next");
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    wait_ready();
    a = 24'h400000; in_valid = 1'b1; out_ready = 1'b1;
    n = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (t1 != IT + 1) begin
      errors++;
      $display("FAIL b2b_latency got %0d exp %0d", t1, IT + 1);
    end
    checks++;
    if (t2 - t1 != IT + 2) begin
      errors++;
      $display("FAIL b2b_period got %0d exp %0d", t2 - t1, IT + 2);
    end
    repeat (30) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stale;
    wait_ready();
    a = 24'h400000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sin_out !== 25'd0 || cos_out !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b busy=%b sin=%h cos=%h exp all 0",
               in_ready, out_valid, busy, sin_out, cos_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got rdy=%b vld=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
    end
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL reset_mid_stale got %0d valid cycles exp 0", stale);
    end
  endtask

`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
  task automatic test_phase_acc();
    test_reset();
    acc_mode = 1'b1;
    run_angle("acc_22", 24'h100000, 24'h100000, 3210181, 7750063); release_out("acc_22");
    run_angle("acc_45", 24'h100000, 24'h200000, 5931642, 5931642); release_out("acc_45");
    run_angle("acc_67", 24'h100000, 24'h300000, 7750063, 3210181); release_out("acc_67");
    run_angle("acc_90", 24'h100000, 24'h400000, 8388608, 0);       release_out("acc_90");
    acc_mode = 1'b0;
    run_angle("acc_load0", 24'h000000, 24'h000000, 0, 8388608);    release_out("acc_load0");
  endtask
`endif

  initial begin
    test_reset();
    test_angles();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef DW_SINCOS_CORDIC_SEQ_PHASE_ACC_EN
    test_phase_acc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish before 500us");
    $fatal(1, "timeout");
  end
endmodule
